// File: rtl/gdp_pkg.sv
// Shared types for the Gaussian distribution probability (gdp) pipeline
// and its downstream senone max-selection stage.
package gdp_pkg;

  // Log-probability word width produced by the gdp pipeline.
  localparam int DATA_W = 16;

  // Default senone geometry.
  localparam int N_GAUSS_DEF   = 8;
  localparam int N_SENONES_DEF = 512;

  // Signed log-probability, shared with gdp's ln_p output.
  typedef logic signed [DATA_W-1:0] lnp_t;

  // Senone accumulation state: IDLE means no partial senone is held.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } gmm_state_t;

endpackage

// File: rtl/gmm_max_select_if.sv
// Stream bundle between the gdp result port, gmm_max_select and the
// senone score consumer.
interface gmm_max_select_if
  import gdp_pkg::*;
#(
  parameter int N_GAUSS   = N_GAUSS_DEF,
  parameter int N_SENONES = N_SENONES_DEF
) ();

  localparam int GW = $clog2(N_GAUSS);
  localparam int SW = $clog2(N_SENONES);

  // Upstream side: frame control and gdp results.
  logic          frame_start;
  logic          data_ready;
  lnp_t          ln_p;

  // Downstream side: per-senone results and status pulses.
  logic          score_valid;
  lnp_t          senone_score;
  logic [GW-1:0] best_idx;
  logic [SW-1:0] senone_id;
  logic          frame_done;
  logic          abort_err;

  // Producer / consumer view (drives frame control and samples, reads results).
  modport master (
    output frame_start, data_ready, ln_p,
    input  score_valid, senone_score, best_idx, senone_id, frame_done, abort_err
  );

  // Max-select block view.
  modport slave (
    input  frame_start, data_ready, ln_p,
    output score_valid, senone_score, best_idx, senone_id, frame_done, abort_err
  );

endinterface

// File: rtl/gmm_max_select_max_cmp.sv
// Combinational compare-and-select of the running senone maximum against
// a new candidate. Strict greater-than, so ties keep the earlier index.
module max_cmp
  import gdp_pkg::*;
#(
  parameter int GW = 3
) (
  input  lnp_t          i_best,
  input  logic [GW-1:0] i_best_i,
  input  lnp_t          i_cand,
  input  logic [GW-1:0] i_cand_i,
  output lnp_t          o_best,
  output logic [GW-1:0] o_best_i
);

  logic w_take;

  // Signed compare: 16'h8000 is the smallest score, 16'h7FFF the largest.
  assign w_take = (i_cand > i_best);

  // Select the winner of the pair.
  always_comb begin
    o_best   = i_best;
    o_best_i = i_best_i;
    if (w_take) begin
      o_best   = i_cand;
      o_best_i = i_cand_i;
    end
  end

endmodule

// File: rtl/gmm_max_select.sv
// Groups the gdp log-probability stream into senones of N_GAUSS components,
// emits the per-senone maximum (Viterbi approximation of the log-sum) with
// its winning component index and senone id, and flags end of frame.
module gmm_max_select
  import gdp_pkg::*;
#(
  parameter int N_GAUSS   = N_GAUSS_DEF,
  parameter int N_SENONES = N_SENONES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  gmm_max_select_if.slave  bus
);

  localparam int GW = $clog2(N_GAUSS);
  localparam int SW = $clog2(N_SENONES);

  localparam logic [GW-1:0] LAST_G = GW'(N_GAUSS - 1);
  localparam logic [SW-1:0] LAST_S = SW'(N_SENONES - 1);

  // Accumulation state.
  gmm_state_t    r_state;
  logic [GW-1:0] r_g_cnt;
  logic [SW-1:0] r_s_cnt;
  lnp_t          r_best;
  logic [GW-1:0] r_best_i;

  // Registered outputs.
  logic          r_score_valid;
  lnp_t          r_senone_score;
  logic [GW-1:0] r_best_idx;
  logic [SW-1:0] r_senone_id;
  logic          r_frame_done;
  logic          r_abort_err;

  // Compare result of running max against the incoming sample.
  lnp_t          w_new_best;
  logic [GW-1:0] w_new_best_i;

  max_cmp #(
    .GW (GW)
  ) u_max_cmp (
    .i_best   (r_best),
    .i_best_i (r_best_i),
    .i_cand   (bus.ln_p),
    .i_cand_i (r_g_cnt),
    .o_best   (w_new_best),
    .o_best_i (w_new_best_i)
  );

  // Senone FSM: accumulate the max per component, register the result when
  // the last component arrives, and handle frame restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_g_cnt        <= '0;
      r_s_cnt        <= '0;
      r_best         <= '0;
      r_best_i       <= '0;
      r_score_valid  <= 1'b0;
      r_senone_score <= '0;
      r_best_idx     <= '0;
      r_senone_id    <= '0;
      r_frame_done   <= 1'b0;
      r_abort_err    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses; result words hold.
      r_score_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_abort_err   <= 1'b0;

      if (bus.frame_start) begin
        // Restart wins over a coincident sample, which is discarded.
        r_abort_err <= (r_state == ACCUM);
        r_state     <= IDLE;
        r_g_cnt     <= '0;
        r_s_cnt     <= '0;
      end else if (bus.data_ready) begin
        case (r_state)
          IDLE: begin
            r_best   <= bus.ln_p;
            r_best_i <= '0;
            r_g_cnt  <= GW'(1);
            r_state  <= ACCUM;
          end
          ACCUM: begin
            r_best   <= w_new_best;
            r_best_i <= w_new_best_i;
            if (r_g_cnt == LAST_G) begin
              // Last component: publish the senone including this sample.
              r_state        <= IDLE;
              r_g_cnt        <= '0;
              r_score_valid  <= 1'b1;
              r_senone_score <= w_new_best;
              r_best_idx     <= w_new_best_i;
              r_senone_id    <= r_s_cnt;
              r_frame_done   <= (r_s_cnt == LAST_S);
              r_s_cnt        <= (r_s_cnt == LAST_S) ? '0 : r_s_cnt + 1'b1;
            end else begin
              r_g_cnt <= r_g_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_g_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.score_valid  = r_score_valid;
  assign bus.senone_score = r_senone_score;
  assign bus.best_idx     = r_best_idx;
  assign bus.senone_id    = r_senone_id;
  assign bus.frame_done   = r_frame_done;
  assign bus.abort_err    = r_abort_err;

endmodule

// File: tb/tb_gmm_max_select.sv
// Bench for gmm_max_select with 4-component senones and 2-senone frames.
module tb_gmm_max_select;
  import gdp_pkg::*;

  localparam int NG = 4;
  localparam int NS = 2;

  logic clk;
  logic reset;

  gmm_max_select_if #(.N_GAUSS(NG), .N_SENONES(NS)) bus ();

  gmm_max_select #(.N_GAUSS(NG), .N_SENONES(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: samples of the senone in progress, next senone id,
  // and the outputs expected after the next rising edge.
  lnp_t  m_q[$];
  int    m_sid = 0;
  logic  e_sv = 1'b0, e_fd = 1'b0, e_ab = 1'b0;
  lnp_t  e_score = '0;
  int    e_idx = 0, e_id = 0;

  int    cyc_no = 0;
  int    sv_cycles[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".score_valid"},  16'(bus.score_valid),  16'(e_sv));
    chk({tag, ".frame_done"},   16'(bus.frame_done),   16'(e_fd));
    chk({tag, ".abort_err"},    16'(bus.abort_err),    16'(e_ab));
    chk({tag, ".senone_score"}, bus.senone_score,      e_score);
    chk({tag, ".best_idx"},     16'(bus.best_idx),     16'(e_idx));
    chk({tag, ".senone_id"},    16'(bus.senone_id),    16'(e_id));
  endtask

  // Model one clock: what the outputs must show after this edge.
  task automatic model_step(input bit fs, input bit dr, input lnp_t v);
    int bi;
    e_sv = 1'b0; e_fd = 1'b0; e_ab = 1'b0;
    if (fs) begin
      e_ab  = (m_q.size() != 0);
      m_q.delete();
      m_sid = 0;
    end else if (dr) begin
      m_q.push_back(v);
      if (m_q.size() == NG) begin
        bi = 0;
        for (int i = 1; i < NG; i++)
          if (m_q[i] > m_q[bi]) bi = i;
        e_sv    = 1'b1;
        e_score = m_q[bi];
        e_idx   = bi;
        e_id    = m_sid;
        e_fd    = (m_sid == NS - 1);
        m_sid   = (m_sid + 1) % NS;
        m_q.delete();
      end
    end
  endtask

  // Drive one cycle (called just after a falling edge), then check at the
  // next falling edge.
  task automatic cyc(input bit fs, input bit dr, input lnp_t v, input string tag);
    bus.frame_start = fs;
    bus.data_ready  = dr;
    bus.ln_p        = v;
    model_step(fs, dr, v);
    @(negedge clk);
    cyc_no++;
    check_outputs(tag);
    if (bus.score_valid) sv_cycles.push_back(cyc_no);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sid = 0;
    e_sv = 1'b0; e_fd = 1'b0; e_ab = 1'b0;
    e_score = '0; e_idx = 0; e_id = 0;
  endtask

  initial begin
    lnp_t t1 [4];
    lnp_t t2 [4];
    lnp_t r;
    int   pick;

    t1[0] = 16'sh12C7; t1[1] = 16'sh0100; t1[2] = 16'sh2000; t1[3] = 16'shFF00;
    t2[0] = 16'sh8000; t2[1] = 16'sh8001; t2[2] = 16'sh8000; t2[3] = 16'sh8000;

    bus.frame_start = 1'b0;
    bus.data_ready  = 1'b0;
    bus.ln_p        = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b1;
    idle(2, "post_reset");

    // 1: four back-to-back samples, maximum at index 2.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, t1[i], "t1");
    chk("t1_valid", 16'(bus.score_valid), 16'h0001);
    chk("t1_score", bus.senone_score, 16'h2000);
    chk("t1_idx",   16'(bus.best_idx), 16'h0002);
    chk("t1_id",    16'(bus.senone_id), 16'h0000);
    chk("t1_done",  16'(bus.frame_done), 16'h0000);
    idle(1, "t1_hold");
    chk("t1_hold_score", bus.senone_score, 16'h2000);

    // 2: spaced samples near the signed minimum, last senone of the frame.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, t2[i], "t2");
      if (i == 3) begin
        chk("t2_score", bus.senone_score, 16'h8001);
        chk("t2_idx",   16'(bus.best_idx), 16'h0001);
        chk("t2_id",    16'(bus.senone_id), 16'h0001);
        chk("t2_done",  16'(bus.frame_done), 16'h0001);
      end
      idle(3, "t2_gap");
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, lnp_t'($urandom_range(0, 65535)), "t2_wrap");
    chk("t2_wrap_id", 16'(bus.senone_id), 16'h0000);

    // 3: all-equal senone keeps index 0, then a continuous 8-sample burst.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'sh0500, "t3_tie");
    chk("t3_tie_idx",   16'(bus.best_idx), 16'h0000);
    chk("t3_tie_score", bus.senone_score, 16'h0500);
    sv_cycles.delete();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, lnp_t'($urandom_range(0, 65535)), "t3_burst");
    chk("t3_pulses", 16'(sv_cycles.size()), 16'h0002);
    if (sv_cycles.size() == 2)
      chk("t3_spacing", 16'(sv_cycles[1] - sv_cycles[0]), 16'h0004);
    idle(2, "t3_idle");

    // 4: restart after two samples drops the partial senone.
    cyc(1'b0, 1'b1, 16'sh7FFF, "t4");
    cyc(1'b0, 1'b1, 16'sh0001, "t4");
    cyc(1'b1, 1'b0, '0, "t4_fs");
    chk("t4_abort", 16'(bus.abort_err), 16'h0001);
    chk("t4_novalid", 16'(bus.score_valid), 16'h0000);
    idle(1, "t4_idle");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, lnp_t'($urandom_range(0, 65535)), "t4_next");
    chk("t4_id", 16'(bus.senone_id), 16'h0000);
    chk("t4_valid", 16'(bus.score_valid), 16'h0001);

    // 5: restart with a coincident sample while idle.
    cyc(1'b1, 1'b1, 16'sh7FFF, "t5_fs");
    chk("t5_noabort", 16'(bus.abort_err), 16'h0000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, lnp_t'(16'h0010 + 16'(i)), "t5");
    chk("t5_score", bus.senone_score, 16'h0013);
    chk("t5_idx",   16'(bus.best_idx), 16'h0003);
    chk("t5_id",    16'(bus.senone_id), 16'h0000);

    // 6: asynchronous reset in the middle of a senone.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'sh4000, "t6");
    bus.data_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_async");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, lnp_t'(16'sh0100 - 16'sh0040 * i), "t6_after");
    chk("t6_score", bus.senone_score, 16'h0100);
    chk("t6_idx",   16'(bus.best_idx), 16'h0000);
    chk("t6_id",    16'(bus.senone_id), 16'h0000);

    // Random traffic including extremes and occasional restarts.
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      r = 16'sh8000;
      else if (pick == 1) r = 16'sh7FFF;
      else if (pick == 2) r = 16'sh0000;
      else                r = lnp_t'($urandom_range(0, 65535));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gmm_max_select.md
Name: gmm_max_select

Overview:
- Downstream consumer of the Gaussian distribution probability pipeline (gdp).
- Takes the stream of per-Gaussian log-probabilities (ln_p, qualified by the single-cycle data_ready pulse) and groups consecutive results into senones of N_GAUSS mixture components.
- Per senone, selects the maximum ln_p (Viterbi max approximation of the log-sum) and emits senone score, winning component index and senone id.
- Flags end of frame after N_SENONES senones.

Parameters:
- N_GAUSS, 8, Gaussian components per senone (>=2).
- N_SENONES, 512, senones per frame (>=2).
- GW, $clog2(N_GAUSS), width of component index.
- SW, $clog2(N_SENONES), width of senone id.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  synchronous pulse: restart frame (senone id 0, component count 0).
- data_ready  in  1  gdp result valid, one cycle per Gaussian; back-to-back pulses allowed.
- ln_p  in  16  gdp log-probability, signed two's complement.
- score_valid  out  1  one-cycle pulse: senone result outputs valid.
- senone_score  out  16  signed max ln_p of the completed senone.
- best_idx  out  GW  component index (0..N_GAUSS-1) of the maximum.
- senone_id  out  SW  id of the completed senone.
- frame_done  out  1  one-cycle pulse, coincident with score_valid of senone N_SENONES-1.
- abort_err  out  1  one-cycle pulse: frame_start arrived mid-senone.

Behaviour:
- Reset (reset low, async): all outputs 0; g_cnt=0, s_cnt=0, best=0, best_i=0, state IDLE.
- States:
  - IDLE: g_cnt==0, no partial senone.
  - ACCUM: 1 <= g_cnt <= N_GAUSS-1.
- IDLE + data_ready:
  - best<=ln_p, best_i<=0, g_cnt<=1, go ACCUM.
- ACCUM + data_ready:
  - If ln_p > best (signed compare): best<=ln_p, best_i<=g_cnt.
  - Ties keep the earlier index.
  - If g_cnt==N_GAUSS-1, go IDLE and register the final result; otherwise g_cnt++.
- Output latency is exactly 1 cycle after the data_ready of the last component.
  - Next edge: score_valid=1, senone_score=max over all N_GAUSS including the last sample, best_idx, senone_id=s_cnt.
  - Then s_cnt increments, wrapping N_SENONES-1 -> 0.
  - frame_done=1 in the same cycle when the emitted id is N_SENONES-1.
- Output registers hold their last value between pulses; only score_valid/frame_done/abort_err drop to 0.
- A data_ready in the cycle score_valid is high starts the next senone normally (IDLE path); no bubble required.
- frame_start has priority over data_ready in the same cycle: the data sample is discarded, g_cnt=0, s_cnt=0, state IDLE.
  - If the state was ACCUM, abort_err pulses next cycle and the partial senone is dropped (no score_valid).
  - In IDLE, no error.
- Signed extremes: 16'h8000 is the minimum and is a valid score; 16'h7FFF is the maximum. No saturation or arithmetic; pure compare/select.
- No backpressure: the consumer must accept every score_valid pulse.
- Reset asserted mid-senone clears everything asynchronously; no partial output on release.

Decomposition:
- Shared package gdp_pkg:
  - typedef logic signed [15:0] lnp_t (shared with gdp's ln_p).
  - localparam defaults for N_GAUSS and N_SENONES.
  - state enum {IDLE, ACCUM}.
- One natural sub-module: max_cmp.
  - Combinational signed compare-and-select of (best, best_i) vs (ln_p, g_cnt).
  - Returns new best and index; strict greater-than.

Test Plan (bench overrides N_GAUSS=4, N_SENONES=2):
1. Reset low, then high; drive ln_p 16'h12C7, 16'h0100, 16'h2000, 16'hFF00 on 4 consecutive data_ready -> one cycle after the 4th: score_valid=1, senone_score=16'h2000, best_idx=2, senone_id=0, frame_done=0.
2. Continue with second senone 16'h8000, 16'h8001, 16'h8000, 16'h8000, spaced 3 idle cycles apart -> score 16'h8001, idx 1, senone_id=1, frame_done=1; next senone reports id 0.
3. Tie: 16'h0500 x4 back-to-back -> idx 0, score 16'h0500; then an immediate 8-pulse continuous burst -> two score_valid pulses exactly 4 cycles apart.
4. frame_start after 2 of 4 samples -> abort_err pulse next cycle, no score_valid; following 4 samples produce senone_id=0.
5. frame_start and data_ready in the same cycle while IDLE -> sample discarded, abort_err=0; the next 4 samples form one senone.
6. Assert reset mid-senone (after 3 samples) -> all outputs 0 immediately; after release, 4 new samples give a correct result with senone_id=0.
